// File: rtl/hsm_axil_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : hsm_axil_pkg
//  Purpose  : Shared definitions for the HSM AXI4-Lite master and register
//             slave: response codes, master FSM state encoding and the HSM
//             register map byte addresses.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package hsm_axil_pkg;

  // AXI4-Lite response codes
  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  // Master FSM states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WR    = 3'd1,
    ST_WR_B  = 3'd2,
    ST_RD_AR = 3'd3,
    ST_RD_R  = 3'd4,
    ST_RSP   = 3'd5
  } axil_state_e;

  // HSM register map (byte addresses)
  localparam logic [4:0] REG_CTRL     = 5'h00;
  localparam logic [4:0] REG_STATUS   = 5'h04;
  localparam logic [4:0] REG_DATA_IN  = 5'h08;
  localparam logic [4:0] REG_DATA_OUT = 5'h0C;
  localparam logic [4:0] REG_RAW_OSC  = 5'h10;
  localparam logic [4:0] REG_COUNTER  = 5'h14;
  localparam logic [4:0] REG_RAND_OUT = 5'h18;
  localparam logic [4:0] REG_SAMP_CNT = 5'h1C;

endpackage : hsm_axil_pkg
`default_nettype wire

// File: rtl/hsm_axil_master_if.sv
`default_nettype none
// ============================================================================
//  Module   : hsm_axil_master_if
//  Purpose  : AXI4-Lite bus bundle (AW, W, B, AR, R channels) between the
//             HSM fabric master and the HSM register slave.
//  Ports    : modport master - drives AW/W/AR payload+VALID, BREADY, RREADY
//             modport slave  - drives AWREADY/WREADY/ARREADY, B and R channels
//  Revision : 1.0  initial release
// ============================================================================
interface hsm_axil_master_if #(
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] awaddr;
  logic [2:0]        awprot;
  logic              awvalid;
  logic              awready;
  logic [31:0]       wdata;
  logic [3:0]        wstrb;
  logic              wvalid;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;
  logic [ADDR_W-1:0] araddr;
  logic [2:0]        arprot;
  logic              arvalid;
  logic              arready;
  logic [31:0]       rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;

  modport master (
    output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
           araddr, arprot, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface : hsm_axil_master_if
`default_nettype wire

// File: rtl/hsm_axil_master.sv
`default_nettype none
// ============================================================================
//  Module   : hsm_axil_master
//  Purpose  : Single-outstanding AXI4-Lite master converting a command /
//             response stream into AXI4-Lite reads and writes, with a sticky
//             timeout flag for transactions that take too long.
//  Ports    : M_AXI_ACLK, M_AXI_ARESETN (async, active low)
//             cmd_*   : command stream in (valid/ready, write, addr, data, strb)
//             rsp_*   : response stream out (valid/ready, write, rdata, resp)
//             timeout_flag / timeout_clr : sticky timeout status and clear
//             m_axi   : AXI4-Lite master bus (hsm_axil_master_if.master)
//  Revision : 1.0  initial release
// ============================================================================
module hsm_axil_master
  import hsm_axil_pkg::*;
#(
  parameter int C_M_AXI_ADDR_WIDTH = 5,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES     = 256
) (
  input  wire logic                          M_AXI_ACLK,
  input  wire logic                          M_AXI_ARESETN,
  input  wire logic                          cmd_valid,
  output logic                               cmd_ready,
  input  wire logic                          cmd_write,
  input  wire logic [C_M_AXI_ADDR_WIDTH-1:0] cmd_addr,
  input  wire logic [31:0]                   cmd_wdata,
  input  wire logic [3:0]                    cmd_wstrb,
  output logic                               rsp_valid,
  input  wire logic                          rsp_ready,
  output logic                               rsp_write,
  output logic [31:0]                        rsp_rdata,
  output logic [1:0]                         rsp_resp,
  output logic                               timeout_flag,
  input  wire logic                          timeout_clr,
  hsm_axil_master_if.master                  m_axi
);

  // Configuration checks, resolved at elaboration
  if (C_M_AXI_DATA_WIDTH != 32) begin : g_bad_data_width
    $error("hsm_axil_master: C_M_AXI_DATA_WIDTH must be 32");
  end
  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("hsm_axil_master: TIMEOUT_CYCLES must be in 2..65535");
  end

  localparam logic [15:0] c_TIMEOUT = 16'(TIMEOUT_CYCLES);
  localparam logic [15:0] c_CNT_MAX = 16'hFFFF;

  axil_state_e                   r_state;
  axil_state_e                   w_state_nxt;
  logic [C_M_AXI_ADDR_WIDTH-1:0] r_addr;
  logic [31:0]                   r_wdata;
  logic [3:0]                    r_wstrb;
  logic                          r_awvalid;
  logic                          r_wvalid;
  logic                          r_arvalid;
  logic                          r_rsp_write;
  logic [31:0]                   r_rsp_rdata;
  logic [1:0]                    r_rsp_resp;
  logic [15:0]                   r_to_cnt;
  logic                          r_to_flag;

  logic w_cmd_fire;
  logic w_aw_hs;
  logic w_w_hs;
  logic w_ar_hs;
  logic w_b_hs;
  logic w_r_hs;
  logic w_aw_done;
  logic w_w_done;
  logic w_busy;
  logic w_to_event;

  assign w_cmd_fire = cmd_valid & cmd_ready;
  assign w_aw_hs    = r_awvalid & m_axi.awready;
  assign w_w_hs     = r_wvalid  & m_axi.wready;
  assign w_ar_hs    = r_arvalid & m_axi.arready;
  assign w_b_hs     = (r_state == ST_WR_B) & m_axi.bvalid;
  assign w_r_hs     = (r_state == ST_RD_R) & m_axi.rvalid;
  // A write channel is finished once its VALID has dropped or is handshaking now
  assign w_aw_done  = ~r_awvalid | w_aw_hs;
  assign w_w_done   = ~r_wvalid  | w_w_hs;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) r_state <= ST_IDLE;
    else                r_state <= w_state_nxt;
  end

  // ---------------- FSM: next-state logic ----------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_cmd_fire)            w_state_nxt = cmd_write ? ST_WR : ST_RD_AR;
      ST_WR:    if (w_aw_done && w_w_done) w_state_nxt = ST_WR_B;
      ST_WR_B:  if (m_axi.bvalid)          w_state_nxt = ST_RSP;
      ST_RD_AR: if (w_ar_hs)               w_state_nxt = ST_RD_R;
      ST_RD_R:  if (m_axi.rvalid)          w_state_nxt = ST_RSP;
      ST_RSP:   if (rsp_ready)             w_state_nxt = ST_IDLE;
      default:                             w_state_nxt = ST_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  // cmd_ready is gated by reset so it reads 0 while reset is held, even
  // though the state register already sits in IDLE.
  always_comb begin
    cmd_ready    = (r_state == ST_IDLE) & M_AXI_ARESETN;
    m_axi.bready = (r_state == ST_WR_B);
    m_axi.rready = (r_state == ST_RD_R);
    rsp_valid    = (r_state == ST_RSP);
  end

  // ---------------- Request / response datapath ----------------
  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      r_addr      <= '0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_awvalid   <= 1'b0;
      r_wvalid    <= 1'b0;
      r_arvalid   <= 1'b0;
      r_rsp_write <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_resp  <= AXI_RESP_OKAY;
    end else begin
      if (w_cmd_fire) begin
        r_addr    <= cmd_addr;
        r_wdata   <= cmd_write ? cmd_wdata : '0;
        r_wstrb   <= cmd_write ? cmd_wstrb : '0;
        r_awvalid <= cmd_write;
        r_wvalid  <= cmd_write;
        r_arvalid <= ~cmd_write;
      end else begin
        // Each VALID drops only after its own handshake
        if (w_aw_hs) r_awvalid <= 1'b0;
        if (w_w_hs)  r_wvalid  <= 1'b0;
        if (w_ar_hs) r_arvalid <= 1'b0;
      end
      if (w_b_hs) begin
        r_rsp_write <= 1'b1;
        r_rsp_rdata <= '0;
        r_rsp_resp  <= m_axi.bresp;
      end else if (w_r_hs) begin
        r_rsp_write <= 1'b0;
        r_rsp_rdata <= m_axi.rdata;
        r_rsp_resp  <= m_axi.rresp;
      end
    end
  end

  // ---------------- Timeout supervision ----------------
  // Only the waiting states count; the transaction is never abandoned.
  assign w_busy     = (r_state != ST_IDLE) && (r_state != ST_RSP);
  assign w_to_event = w_busy && (r_to_cnt != c_CNT_MAX) && ((r_to_cnt + 16'd1) == c_TIMEOUT);

  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      r_to_cnt  <= '0;
      r_to_flag <= 1'b0;
    end else begin
      if (w_cmd_fire)                          r_to_cnt <= '0;
      else if (w_busy && r_to_cnt != c_CNT_MAX) r_to_cnt <= r_to_cnt + 16'd1;
      // A new timeout event takes priority over a simultaneous clear
      if (w_to_event)       r_to_flag <= 1'b1;
      else if (timeout_clr) r_to_flag <= 1'b0;
    end
  end

  assign m_axi.awaddr  = r_addr;
  assign m_axi.awprot  = 3'b000;
  assign m_axi.awvalid = r_awvalid;
  assign m_axi.wdata   = r_wdata;
  assign m_axi.wstrb   = r_wstrb;
  assign m_axi.wvalid  = r_wvalid;
  assign m_axi.araddr  = r_addr;
  assign m_axi.arprot  = 3'b000;
  assign m_axi.arvalid = r_arvalid;
  assign rsp_write     = r_rsp_write;
  assign rsp_rdata     = r_rsp_rdata;
  assign rsp_resp      = r_rsp_resp;
  assign timeout_flag  = r_to_flag;

endmodule : hsm_axil_master
`default_nettype wire

// File: tb/tb_hsm_axil_master.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hsm_axil_master
//  Purpose  : Self-checking bench for hsm_axil_master with a configurable
//             AXI4-Lite slave model (per-channel READY / response delays,
//             8-word memory with byte strobes).
//  Ports    : none
//  Revision : 1.0  initial release
// ============================================================================
module tb_hsm_axil_master;
  import hsm_axil_pkg::*;

  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [31:0]   cmd_wdata = '0;
  logic [3:0]    cmd_wstrb = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic          rsp_write;
  logic [31:0]   rsp_rdata;
  logic [1:0]    rsp_resp;
  logic          timeout_flag;
  logic          timeout_clr = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  hsm_axil_master_if #(.ADDR_W(AW)) bus ();

  hsm_axil_master #(
    .C_M_AXI_ADDR_WIDTH(AW),
    .C_M_AXI_DATA_WIDTH(32),
    .TIMEOUT_CYCLES    (8)
  ) dut (
    .M_AXI_ACLK   (clk),
    .M_AXI_ARESETN(rst_n),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_write    (cmd_write),
    .cmd_addr     (cmd_addr),
    .cmd_wdata    (cmd_wdata),
    .cmd_wstrb    (cmd_wstrb),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_write    (rsp_write),
    .rsp_rdata    (rsp_rdata),
    .rsp_resp     (rsp_resp),
    .timeout_flag (timeout_flag),
    .timeout_clr  (timeout_clr),
    .m_axi        (bus)
  );

  // ---------------- Slave model ----------------
  int          aw_delay = 0, w_delay = 0, ar_delay = 0, b_delay = 0, r_delay = 0;
  logic [1:0]  bresp_cfg = AXI_RESP_OKAY, rresp_cfg = AXI_RESP_OKAY;
  int          aw_wait, w_wait, ar_wait, b_left, r_left;
  logic        aw_got, w_got, b_pend, r_pend;
  logic [AW-1:0] lat_addr;
  logic [31:0] lat_data;
  logic [3:0]  lat_strb;
  logic [31:0] mem [8];

  wire aw_hs = bus.awvalid & bus.awready;
  wire w_hs  = bus.wvalid  & bus.wready;
  wire ar_hs = bus.arvalid & bus.arready;
  wire both  = (aw_got | aw_hs) & (w_got | w_hs) & ~b_pend;
  wire [AW-1:0] wr_addr = aw_hs ? bus.awaddr : lat_addr;
  wire [31:0]   wr_data = w_hs ? bus.wdata : lat_data;
  wire [3:0]    wr_strb = w_hs ? bus.wstrb : lat_strb;

  assign bus.awready = bus.awvalid && (aw_wait >= aw_delay);
  assign bus.wready  = bus.wvalid  && (w_wait  >= w_delay);
  assign bus.arready = bus.arvalid && (ar_wait >= ar_delay);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aw_wait <= 0; w_wait <= 0; ar_wait <= 0; b_left <= 0; r_left <= 0;
      aw_got <= 1'b0; w_got <= 1'b0; b_pend <= 1'b0; r_pend <= 1'b0;
      lat_addr <= '0; lat_data <= '0; lat_strb <= '0;
      bus.bvalid <= 1'b0; bus.bresp <= 2'b00;
      bus.rvalid <= 1'b0; bus.rresp <= 2'b00; bus.rdata <= '0;
      for (int i = 0; i < 8; i++) mem[i] <= '0;
    end else begin
      aw_wait <= (bus.awvalid && !bus.awready) ? aw_wait + 1 : 0;
      w_wait  <= (bus.wvalid  && !bus.wready)  ? w_wait + 1  : 0;
      ar_wait <= (bus.arvalid && !bus.arready) ? ar_wait + 1 : 0;
      if (aw_hs) begin aw_got <= 1'b1; lat_addr <= bus.awaddr; end
      if (w_hs)  begin w_got <= 1'b1; lat_data <= bus.wdata; lat_strb <= bus.wstrb; end
      if (both) begin
        aw_got <= 1'b0; w_got <= 1'b0; b_pend <= 1'b1;
        for (int i = 0; i < 4; i++)
          if (wr_strb[i]) mem[wr_addr[4:2]][8*i +: 8] <= wr_data[8*i +: 8];
        bus.bvalid <= (b_delay == 0);
        b_left     <= b_delay;
        bus.bresp  <= bresp_cfg;
      end else if (b_pend && !bus.bvalid) begin
        if (b_left <= 1) bus.bvalid <= 1'b1;
        b_left <= b_left - 1;
      end
      if (bus.bvalid && bus.bready) begin bus.bvalid <= 1'b0; b_pend <= 1'b0; end
      if (ar_hs) begin
        r_pend <= 1'b1;
        bus.rdata  <= mem[bus.araddr[4:2]];
        bus.rresp  <= rresp_cfg;
        bus.rvalid <= (r_delay == 0);
        r_left     <= r_delay;
      end else if (r_pend && !bus.rvalid) begin
        if (r_left <= 1) bus.rvalid <= 1'b1;
        r_left <= r_left - 1;
      end
      if (bus.rvalid && bus.rready) begin bus.rvalid <= 1'b0; r_pend <= 1'b0; end
    end
  end

  // ---------------- Bus monitors (cumulative counts) ----------------
  int          awv_cnt = 0, wv_cnt = 0, arv_cnt = 0, bhs_cnt = 0, aw_unstable = 0;
  logic [AW-1:0] exp_awaddr = '0;
  always @(negedge clk) begin
    if (bus.awvalid) awv_cnt++;
    if (bus.wvalid)  wv_cnt++;
    if (bus.arvalid) arv_cnt++;
    if (bus.bvalid && bus.bready) bhs_cnt++;
    if (bus.awvalid && bus.awaddr != exp_awaddr) aw_unstable++;
  end

  // ---------------- Helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  // Starts just after a negedge with the DUT idle; returns at the negedge
  // where rsp_valid is first seen. lat = cycles from accept to rsp_valid.
  task automatic do_cmd(input logic wr, input logic [AW-1:0] addr, input logic [31:0] d,
                        input logic [3:0] s, output int lat);
    exp_awaddr = addr;
    cmd_write = wr; cmd_addr = addr; cmd_wdata = d; cmd_wstrb = s;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!rsp_valid && lat < 60);
    if (!rsp_valid) check("rsp_valid_wait_timeout", 32'(rsp_valid), 32'd1);
  endtask

  task automatic consume();
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    @(negedge clk);
  endtask

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    logic [3:0]    wstrb;
    logic [1:0]    bresp;
    logic [1:0]    rresp;
    logic [31:0]   exp_rdata;
    logic [1:0]    exp_resp;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, a0, w0, r0, b0, u0, flag_n, bready_bad, stable_bad, n;

    vecs[0] = '{1'b1, REG_CTRL,     32'h0000_0001, 4'hF, AXI_RESP_OKAY,   AXI_RESP_OKAY,   32'h0000_0000, AXI_RESP_OKAY};
    vecs[1] = '{1'b1, REG_DATA_IN,  32'hCAFE_F00D, 4'hF, AXI_RESP_OKAY,   AXI_RESP_OKAY,   32'h0000_0000, AXI_RESP_OKAY};
    vecs[2] = '{1'b0, REG_DATA_IN,  32'h0,         4'h0, AXI_RESP_OKAY,   AXI_RESP_OKAY,   32'hCAFE_F00D, AXI_RESP_OKAY};
    vecs[3] = '{1'b1, REG_DATA_OUT, 32'h1234_5678, 4'h3, AXI_RESP_SLVERR, AXI_RESP_OKAY,   32'h0000_0000, AXI_RESP_SLVERR};
    vecs[4] = '{1'b0, REG_DATA_OUT, 32'h0,         4'h0, AXI_RESP_OKAY,   AXI_RESP_OKAY,   32'h0000_5678, AXI_RESP_OKAY};
    vecs[5] = '{1'b0, REG_CTRL,     32'h0,         4'h0, AXI_RESP_OKAY,   AXI_RESP_DECERR, 32'h0000_0001, AXI_RESP_DECERR};
    vecs[6] = '{1'b1, REG_SAMP_CNT, 32'hAABB_CCDD, 4'h8, AXI_RESP_DECERR, AXI_RESP_OKAY,   32'h0000_0000, AXI_RESP_DECERR};
    vecs[7] = '{1'b0, REG_SAMP_CNT, 32'h0,         4'h0, AXI_RESP_OKAY,   AXI_RESP_EXOKAY, 32'hAA00_0000, AXI_RESP_EXOKAY};

    // ---- Reset state ----
    repeat (2) @(negedge clk);
    check("rst_cmd_ready",    32'(cmd_ready),    32'd0);
    check("rst_rsp_valid",    32'(rsp_valid),    32'd0);
    check("rst_rsp_data",     rsp_rdata,         32'd0);
    check("rst_valids",       32'({bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready}), 32'd0);
    check("rst_addr_data",    32'({bus.awaddr, bus.araddr, bus.wstrb}) | bus.wdata, 32'd0);
    check("rst_prot",         32'({bus.awprot, bus.arprot}), 32'd0);
    check("rst_timeout_flag", 32'(timeout_flag), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);

    // ---- Table-driven zero-wait transactions ----
    for (int i = 0; i < 8; i++) begin
      bresp_cfg = vecs[i].bresp;
      rresp_cfg = vecs[i].rresp;
      a0 = awv_cnt; w0 = wv_cnt; r0 = arv_cnt; b0 = bhs_cnt;
      do_cmd(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, lat);
      check($sformatf("v%0d_latency", i),   32'(lat),       32'd3);
      check($sformatf("v%0d_rsp_write", i), 32'(rsp_write), 32'(vecs[i].wr));
      check($sformatf("v%0d_rsp_rdata", i), rsp_rdata,     vecs[i].exp_rdata);
      check($sformatf("v%0d_rsp_resp", i),  32'(rsp_resp),  32'(vecs[i].exp_resp));
      if (vecs[i].wr) begin
        check($sformatf("v%0d_awvalid_cycles", i), 32'(awv_cnt - a0), 32'd1);
        check($sformatf("v%0d_wvalid_cycles", i),  32'(wv_cnt - w0),  32'd1);
        check($sformatf("v%0d_b_handshakes", i),   32'(bhs_cnt - b0), 32'd1);
      end else begin
        check($sformatf("v%0d_arvalid_cycles", i), 32'(arv_cnt - r0), 32'd1);
      end
      consume();
    end

    // ---- AWREADY delayed 3 cycles, WREADY immediate ----
    bresp_cfg = AXI_RESP_OKAY; aw_delay = 3;
    a0 = awv_cnt; w0 = wv_cnt; b0 = bhs_cnt; u0 = aw_unstable;
    do_cmd(1'b1, REG_COUNTER, 32'h0000_55AA, 4'hF, lat);
    check("awdly_latency",        32'(lat),               32'd6);
    check("awdly_awvalid_cycles", 32'(awv_cnt - a0),      32'd4);
    check("awdly_wvalid_cycles",  32'(wv_cnt - w0),       32'd1);
    check("awdly_b_handshakes",   32'(bhs_cnt - b0),      32'd1);
    check("awdly_awaddr_stable",  32'(aw_unstable - u0),  32'd0);
    check("awdly_rsp_write",      32'(rsp_write),         32'd1);
    consume();
    aw_delay = 0;

    // ---- Error response read with stalled consumer ----
    do_cmd(1'b1, REG_RAW_OSC, 32'hDEAD_BEEF, 4'hF, lat);
    consume();
    rresp_cfg = AXI_RESP_SLVERR;
    do_cmd(1'b0, REG_RAW_OSC, 32'h0, 4'h0, lat);
    stable_bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (!rsp_valid || cmd_ready || rsp_write || rsp_rdata != 32'hDEAD_BEEF || rsp_resp != 2'b10)
        stable_bad++;
      @(negedge clk);
    end
    check("stall_rsp_stable", 32'(stable_bad), 32'd0);
    check("stall_rsp_rdata",  rsp_rdata,       32'hDEAD_BEEF);
    consume();
    check("stall_back_idle",  32'(cmd_ready),  32'd1);
    check("stall_no_timeout", 32'(timeout_flag), 32'd0);
    rresp_cfg = AXI_RESP_OKAY;

    // ---- Timeout: BVALID withheld 20 cycles ----
    b_delay = 20;
    exp_awaddr = REG_STATUS;
    cmd_write = 1'b1; cmd_addr = REG_STATUS; cmd_wdata = 32'h1; cmd_wstrb = 4'hF;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    n = 0; flag_n = 0; bready_bad = 0;
    do begin
      @(negedge clk);
      n++;
      if (timeout_flag && flag_n == 0) flag_n = n;
      if (n >= 2 && !rsp_valid && !bus.bready) bready_bad++;
    end while (!rsp_valid && n < 60);
    check("to_flag_cycle",     32'(flag_n),       32'd9);
    check("to_bready_held",    32'(bready_bad),   32'd0);
    check("to_rsp_cycle",      32'(n),            32'd23);
    check("to_flag_at_rsp",    32'(timeout_flag), 32'd1);
    consume();
    check("to_flag_sticky",    32'(timeout_flag), 32'd1);
    timeout_clr = 1'b1;
    @(posedge clk);
    #1 timeout_clr = 1'b0;
    @(negedge clk);
    check("to_flag_cleared",   32'(timeout_flag), 32'd0);
    b_delay = 0;

    // ---- Asynchronous reset mid-read ----
    ar_delay = 5;
    cmd_write = 1'b0; cmd_addr = REG_RAND_OUT; cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("arst_arvalid_before", 32'(bus.arvalid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("arst_arvalid",   32'(bus.arvalid), 32'd0);
    check("arst_rready",    32'(bus.rready),  32'd0);
    check("arst_rsp_valid", 32'(rsp_valid),   32'd0);
    check("arst_cmd_ready", 32'(cmd_ready),   32'd0);
    @(negedge clk);
    ar_delay = 0;
    rst_n = 1'b1;
    @(negedge clk);
    check("arst_release_cmd_ready", 32'(cmd_ready),   32'd1);
    check("arst_release_arvalid",   32'(bus.arvalid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule : tb_hsm_axil_master
`default_nettype wire
